cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic.sv | 111 +++++++++++
 tb/tb_cond_logic.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution stage: evaluates Cond against stored NZCV flags, gates
// decoder controls, and registers them. Define COND_STATS_EN to add fire/squash counters.
module cond_logic (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Valid_i,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  output logic        CondEx,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        Valid_o,
  output logic [3:0]  Flags
`ifdef COND_STATS_EN
  ,
  output logic [15:0] ExecCount,
  output logic [15:0] SquashCount
`endif
);

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = ~z;
      4'd2:    cond_pass = c;
      4'd3:    cond_pass = ~c;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = ~n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = ~v;
      4'd8:    cond_pass = c & ~z;
      4'd9:    cond_pass = ~c | z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = ~z & (n == v);
      4'd13:   cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  logic cond_ex_s;
  logic fire_s;
  logic squash_s;
  logic advance_s;

  // Condition evaluation always uses the flags stored before this edge.
  always_comb begin
    cond_ex_s = cond_pass(Cond, Flags);
    advance_s = ~Stall & ~Flush;
    fire_s    = Valid_i & cond_ex_s & advance_s;
    squash_s  = Valid_i & ~cond_ex_s & advance_s;
  end

  assign CondEx = cond_ex_s;

  // Output stage: flush clears, stall holds, otherwise load gated controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Valid_o  <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end else if (Flush) begin
      Valid_o  <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end else if (!Stall) begin
      Valid_o  <= Valid_i;
      PCSrc    <= PCS  & cond_ex_s & Valid_i;
      RegWrite <= RegW & cond_ex_s & Valid_i;
      MemWrite <= MemW & cond_ex_s & Valid_i;
    end
  end

  // Flag register: N,Z and C,V halves are written independently, only on fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Flags <= 4'b0000;
    end else if (fire_s) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_STATS_EN
  // Statistics counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ExecCount   <= 16'd0;
      SquashCount <= 16'd0;
    end else begin
      if (fire_s)   ExecCount   <= ExecCount + 16'd1;
      if (squash_s) SquashCount <= SquashCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed vector table, random stimulus against an NZCV
// reference model, async reset checks, and counter wrap when COND_STATS_EN is set.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Valid_i = 1'b0, Stall = 1'b0, Flush = 1'b0;
  logic [3:0] Cond = 4'd0, ALUFlags = 4'd0;
  logic [1:0] FlagW = 2'd0;
  logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0;
  logic       CondEx, PCSrc, RegWrite, MemWrite, Valid_o;
  logic [3:0] Flags;
`ifdef COND_STATS_EN
  logic [15:0] ExecCount, SquashCount;
`endif

  int checks = 0;
  int errors = 0;

  cond_logic dut (
    .clk(clk), .rst_n(rst_n), .Valid_i(Valid_i), .Stall(Stall), .Flush(Flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Valid_o(Valid_o), .Flags(Flags)
`ifdef COND_STATS_EN
    , .ExecCount(ExecCount), .SquashCount(SquashCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid, stall, flush;
    logic [3:0] cond, alu;
    logic [1:0] flagw;
    logic       pcs, regw, memw;
    logic       e_condex, e_valid, e_pcsrc, e_regw, e_memw;
    logic [3:0] e_flags;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " Valid_o"},  {15'd0, Valid_o},  16'd0);
    chk({tag, " PCSrc"},    {15'd0, PCSrc},    16'd0);
    chk({tag, " RegWrite"}, {15'd0, RegWrite}, 16'd0);
    chk({tag, " MemWrite"}, {15'd0, MemWrite}, 16'd0);
    chk({tag, " Flags"},    {12'd0, Flags},    16'd0);
  endtask

  // Reference: condition codes written from the named NZCV meaning.
  function automatic logic ref_cond(input logic [3:0] cond, input logic n, z, c, v);
    logic ge;
    ge = (n == v);
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return ge;
      4'd11: return !ge;
      4'd12: return !z && ge;
      4'd13: return z || !ge;
      default: return 1'b1;
    endcase
  endfunction

  logic m_n, m_z, m_c, m_v, m_valid, m_pcsrc, m_regw, m_memw;

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    {m_valid, m_pcsrc, m_regw, m_memw} = 4'b0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1,0,0, 4'd0, 4'b0000,2'b00, 0,1,0, 0, 1,0,0,0, 4'b0000}; // EQ fails after reset
    vecs[1]  = '{1,0,0, 4'd14,4'b0100,2'b11, 0,0,0, 1, 1,0,0,0, 4'b0100}; // AL writes Z
    vecs[2]  = '{1,0,0, 4'd0, 4'b0000,2'b00, 0,1,0, 1, 1,0,1,0, 4'b0100}; // EQ now passes
    vecs[3]  = '{1,0,0, 4'd14,4'b1001,2'b11, 0,0,0, 1, 1,0,0,0, 4'b1001};
    vecs[4]  = '{1,0,0, 4'd10,4'b0000,2'b00, 0,0,1, 1, 1,0,0,1, 4'b1001}; // GE passes
    vecs[5]  = '{1,0,0, 4'd11,4'b0110,2'b11, 0,0,1, 0, 1,0,0,0, 4'b1001}; // LT fails, no flag write
    vecs[6]  = '{1,1,1, 4'd14,4'b0000,2'b11, 1,0,0, 1, 0,0,0,0, 4'b1001}; // flush beats stall
    vecs[7]  = '{1,0,0, 4'd14,4'b0000,2'b00, 1,0,0, 1, 1,1,0,0, 4'b1001};
    vecs[8]  = '{1,1,0, 4'd14,4'b0000,2'b11, 0,1,0, 1, 1,1,0,0, 4'b1001}; // stall holds
    vecs[9]  = '{0,0,0, 4'd14,4'b0000,2'b11, 1,0,0, 1, 0,0,0,0, 4'b1001}; // invalid: no write
    vecs[10] = '{1,0,1, 4'd14,4'b0000,2'b11, 1,1,1, 1, 0,0,0,0, 4'b1001}; // flush: flags hold
    vecs[11] = '{1,0,0, 4'd8, 4'b0000,2'b00, 0,1,0, 0, 1,0,0,0, 4'b1001}; // HI fails (C=0)

    #3 chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      Valid_i = vecs[i].valid; Stall = vecs[i].stall; Flush = vecs[i].flush;
      Cond = vecs[i].cond; ALUFlags = vecs[i].alu; FlagW = vecs[i].flagw;
      PCS = vecs[i].pcs; RegW = vecs[i].regw; MemW = vecs[i].memw;
      #3 chk($sformatf("vec%0d CondEx", i), {15'd0, CondEx}, {15'd0, vecs[i].e_condex});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d Valid_o", i),  {15'd0, Valid_o},  {15'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d PCSrc", i),    {15'd0, PCSrc},    {15'd0, vecs[i].e_pcsrc});
      chk($sformatf("vec%0d RegWrite", i), {15'd0, RegWrite}, {15'd0, vecs[i].e_regw});
      chk($sformatf("vec%0d MemWrite", i), {15'd0, MemWrite}, {15'd0, vecs[i].e_memw});
      chk($sformatf("vec%0d Flags", i),    {12'd0, Flags},    {12'd0, vecs[i].e_flags});
    end

    do_reset();

    for (int i = 0; i < 400; i++) begin
      logic ce, fire;
      Valid_i  = ($urandom_range(0, 9) != 0);
      Stall    = ($urandom_range(0, 7) == 0);
      Flush    = ($urandom_range(0, 9) == 0);
      Cond     = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW    = 2'($urandom_range(0, 3));
      PCS      = 1'($urandom_range(0, 1));
      RegW     = 1'($urandom_range(0, 1));
      MemW     = 1'($urandom_range(0, 1));
      ce = ref_cond(Cond, m_n, m_z, m_c, m_v);
      #3 chk("rand CondEx", {15'd0, CondEx}, {15'd0, ce});
      fire = Valid_i && ce && !Stall && !Flush;
      if (Flush) begin
        {m_valid, m_pcsrc, m_regw, m_memw} = 4'b0000;
      end else if (!Stall) begin
        m_valid = Valid_i;
        m_pcsrc = PCS && ce && Valid_i;
        m_regw  = RegW && ce && Valid_i;
        m_memw  = MemW && ce && Valid_i;
      end
      if (fire && FlagW[1]) {m_n, m_z} = ALUFlags[3:2];
      if (fire && FlagW[0]) {m_c, m_v} = ALUFlags[1:0];
      @(posedge clk);
      #1;
      chk("rand Valid_o",  {15'd0, Valid_o},  {15'd0, m_valid});
      chk("rand PCSrc",    {15'd0, PCSrc},    {15'd0, m_pcsrc});
      chk("rand RegWrite", {15'd0, RegWrite}, {15'd0, m_regw});
      chk("rand MemWrite", {15'd0, MemWrite}, {15'd0, m_memw});
      chk("rand Flags",    {12'd0, Flags},    {12'd0, m_n, m_z, m_c, m_v});
      if (i == 200) begin
        Valid_i = 1'b0; Stall = 1'b0; Flush = 1'b0;
        do_reset();
      end
    end

`ifdef COND_STATS_EN
    Valid_i = 1'b0; Stall = 1'b0; Flush = 1'b0; FlagW = 2'b00;
    do_reset();
    chk("exec reset", ExecCount, 16'h0000);
    Valid_i = 1'b1; Cond = 4'd14;
    repeat (65535) @(posedge clk);
    Valid_i = 1'b0;
    #1 chk("exec preload", ExecCount, 16'hFFFF);
    Valid_i = 1'b1;
    @(posedge clk);
    Valid_i = 1'b0;
    #1 chk("exec wrap", ExecCount, 16'h0000);
    Valid_i = 1'b1; Cond = 4'd0;
    @(posedge clk);
    Valid_i = 1'b0;
    #1 chk("squash count", SquashCount, 16'h0001);
    chk("exec after squash", ExecCount, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
